// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, write masks,
// op encodings, mstatus field positions and interrupt cause codes.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // CSR addresses
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mip / mie bit positions
    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    // Software-writable bits per CSR. MPP is M-only, so it is never
    // software-writable; only trap entry and MRET load it (always 2'b11).
    localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK_V  = 32'hFFFF_FFFD;  // MODE 0/1 legal
    localparam logic [31:0] MTVEC_WMASK_D  = 32'hFFFF_FFFC;  // MODE stuck at 0
    localparam logic [31:0] MEPC_WMASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] FULL_WMASK     = 32'hFFFF_FFFF;
    localparam logic [31:0] NO_WMASK       = 32'h0000_0000;

    // Interrupt cause codes
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    // Zicsr read-modify-write result before masking
    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old,
                                                 input logic [31:0] wsrc);
        case (op)
            CSR_RW:  return wsrc;
            CSR_RS:  return old | wsrc;
            CSR_RC:  return old & ~wsrc;
            default: return old;
        endcase
    endfunction

    // Keep non-writable bits, take writable bits from the new value
    function automatic logic [31:0] csr_merge(input logic [31:0] old,
                                              input logic [31:0] nval,
                                              input logic [31:0] mask);
        return (old & ~mask) | (nval & mask);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter of CNT_WIDTH bits with 32-bit low/high write and read
// ports. A write to either half takes priority over the increment.
module csr_counter64 #(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi
);

    localparam int HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] cnt;

    // Half-word writes replace that half only (no carry); otherwise count and wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt[31:0] <= wdata;
        end else if (wr_hi) begin
            cnt[CNT_WIDTH-1:32] <= wdata[HI_W-1:0];
        end else if (inc) begin
            cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign rd_lo = cnt[31:0];
    assign rd_hi = 32'(cnt[CNT_WIDTH-1:32]);

endmodule

// File: rtl/csr_unit.sv
// Machine-mode RV32 CSR unit: Zicsr read-modify-write, illegal-access
// detection, trap entry / MRET with registered PC redirect, mcycle/minstret
// counters and interrupt pending/enable arbitration.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter int          HART_ID     = 0,
    parameter int          VECTORED_EN = 1,
    parameter int          CNT_WIDTH   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  csr_op,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wsrc,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instret_inc,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mstatus_o
);

    localparam logic [31:0] MTVEC_WMASK = (VECTORED_EN != 0) ? MTVEC_WMASK_V : MTVEC_WMASK_D;

    csr_op_e     op;
    logic        access;
    logic        known;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] old_val;
    logic [31:0] wmask;
    logic [31:0] wr_data;

    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip_q;
    logic [31:0] mip_next;
    logic [31:0] irq_pend;

    logic [31:0] mcycle_lo;
    logic [31:0] mcycle_hi;
    logic [31:0] minstret_lo;
    logic [31:0] minstret_hi;
    logic        hit_mcycle;
    logic        hit_minstret;

    logic [31:0] trap_base;
    logic        trap_vectored;
    logic [31:0] trap_target;

    assign op     = csr_op_e'(csr_op);
    assign access = (op != CSR_NONE);

    // Address decode: old value, legality and writable-bit mask of the selected CSR
    always_comb begin
        old_val = '0;
        known   = 1'b0;
        wmask   = NO_WMASK;
        case (csr_addr)
            ADDR_MSTATUS:   begin old_val = mstatus_q;   known = 1'b1; wmask = MSTATUS_WMASK; end
            ADDR_MISA:      begin old_val = MISA_VALUE;  known = 1'b1; end
            ADDR_MIE:       begin old_val = mie_q;       known = 1'b1; wmask = MIE_WMASK;     end
            ADDR_MTVEC:     begin old_val = mtvec_q;     known = 1'b1; wmask = MTVEC_WMASK;   end
            ADDR_MSCRATCH:  begin old_val = mscratch_q;  known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MEPC:      begin old_val = mepc_q;      known = 1'b1; wmask = MEPC_WMASK;    end
            ADDR_MCAUSE:    begin old_val = mcause_q;    known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MTVAL:     begin old_val = mtval_q;     known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MIP:       begin old_val = mip_q;       known = 1'b1; end
            ADDR_MCYCLE:    begin old_val = mcycle_lo;   known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MCYCLEH:   begin old_val = mcycle_hi;   known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MINSTRET:  begin old_val = minstret_lo; known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MINSTRETH: begin old_val = minstret_hi; known = 1'b1; wmask = FULL_WMASK;    end
            ADDR_MVENDORID: begin old_val = '0;          known = 1'b1; end
            ADDR_MARCHID:   begin old_val = '0;          known = 1'b1; end
            ADDR_MIMPID:    begin old_val = '0;          known = 1'b1; end
            ADDR_MHARTID:   begin old_val = 32'(HART_ID); known = 1'b1; end
            default:        ;
        endcase
    end

    assign csr_rdata   = access ? old_val : '0;
    assign csr_illegal = access && (!known || (csr_we && (csr_addr[11:10] == 2'b11)));

    // A legal write request; trap and MRET take the cycle away from it
    assign wr_req  = access && csr_we && !csr_illegal;
    assign wr_en   = wr_req && !trap_valid && !mret_valid;
    assign wr_data = csr_merge(old_val, csr_apply_op(op, old_val, csr_wsrc), wmask);

    // Counter increments are suppressed whenever software targets that counter
    assign hit_mcycle   = (csr_addr == ADDR_MCYCLE)   || (csr_addr == ADDR_MCYCLEH);
    assign hit_minstret = (csr_addr == ADDR_MINSTRET) || (csr_addr == ADDR_MINSTRETH);

    csr_counter64 #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (!(wr_req && hit_mcycle)),
        .wr_lo (wr_en && (csr_addr == ADDR_MCYCLE)),
        .wr_hi (wr_en && (csr_addr == ADDR_MCYCLEH)),
        .wdata (wr_data),
        .rd_lo (mcycle_lo),
        .rd_hi (mcycle_hi)
    );

    csr_counter64 #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc && !(wr_req && hit_minstret)),
        .wr_lo (wr_en && (csr_addr == ADDR_MINSTRET)),
        .wr_hi (wr_en && (csr_addr == ADDR_MINSTRETH)),
        .wdata (wr_data),
        .rd_lo (minstret_lo),
        .rd_hi (minstret_hi)
    );

    // Trap target: base, or base + 4*cause for vectored interrupts
    assign trap_base     = {mtvec_q[31:2], 2'b00};
    assign trap_vectored = (VECTORED_EN != 0) && (mtvec_q[1:0] == 2'b01) && trap_cause[31];
    assign trap_target   = trap_vectored ? (trap_base + {25'b0, trap_cause[4:0], 2'b00}) : trap_base;

    // Architectural CSR state: trap entry beats MRET, both beat a software write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & ~32'h3;
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
            mstatus_q[MSTATUS_MIE]  <= 1'b0;
            mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
        end else if (mret_valid) begin
            mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
            mstatus_q[MSTATUS_MPIE] <= 1'b1;
            mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
        end else if (wr_en) begin
            case (csr_addr)
                ADDR_MSTATUS:  mstatus_q  <= wr_data;
                ADDR_MIE:      mie_q      <= wr_data;
                ADDR_MTVEC:    mtvec_q    <= wr_data;
                ADDR_MSCRATCH: mscratch_q <= wr_data;
                ADDR_MEPC:     mepc_q     <= wr_data;
                ADDR_MCAUSE:   mcause_q   <= wr_data;
                ADDR_MTVAL:    mtval_q    <= wr_data;
                default:       ;
            endcase
        end
    end

    assign mip_next = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

    // Pending bits are a one-cycle registered copy of the interrupt lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_q <= '0;
        end else begin
            mip_q <= mip_next;
        end
    end

    assign irq_pend = mip_q & mie_q;
    assign irq_req  = mstatus_q[MSTATUS_MIE] && (|irq_pend);

    // Fixed priority: external, then software, then timer
    always_comb begin
        irq_cause = '0;
        if (irq_pend[IRQ_MEI_BIT]) begin
            irq_cause = CAUSE_MEI;
        end else if (irq_pend[IRQ_MSI_BIT]) begin
            irq_cause = CAUSE_MSI;
        end else if (irq_pend[IRQ_MTI_BIT]) begin
            irq_cause = CAUSE_MTI;
        end
    end

    // One-cycle redirect pulse to fetch, issued the cycle after trap or MRET
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_valid || mret_valid;
            if (trap_valid) begin
                redirect_pc <= trap_target;
            end else if (mret_valid) begin
                redirect_pc <= mepc_q;
            end
        end
    end

    assign mstatus_o = mstatus_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: table of CSR access vectors plus
// hand-written trap, interrupt, counter, priority and reset sequences.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0080;
    localparam int          HART      = 3;

    logic        clk;
    logic        rst;
    logic [1:0]  csr_op;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wsrc;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        instret_inc;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mstatus_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wsrc;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs [20];
    sb_t  sb_q [$];

    csr_unit #(
        .MTVEC_RESET (MTVEC_RST),
        .MISA_VALUE  (32'h4000_0100),
        .HART_ID     (HART),
        .VECTORED_EN (1),
        .CNT_WIDTH   (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_op         (csr_op),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wsrc       (csr_wsrc),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .instret_inc    (instret_inc),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .irq_sw         (irq_sw),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mstatus_o      (mstatus_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got %h, expected a queued entry", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic we, input logic [11:0] a, input logic [31:0] d);
        csr_op   = op;
        csr_we   = we;
        csr_addr = a;
        csr_wsrc = d;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        drive(op, 1'b1, a, d);
        tick();
        idle();
    endtask

    task automatic chk_rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(2'b10, 1'b0, a, 32'h0);
        #1;
        check(name, csr_rdata, exp);
        idle();
    endtask

    task automatic event_redirect(input logic t, input logic m, input logic [31:0] cause,
                                  input logic [31:0] pc, input logic [31:0] tval,
                                  input string name, input logic [31:0] exp_pc);
        trap_valid = t;
        mret_valid = m;
        trap_cause = cause;
        trap_pc    = pc;
        trap_tval  = tval;
        sb_push(name, exp_pc);
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        check({name, "_valid"}, {31'b0, redirect_valid}, 32'd1);
        sb_pop_check(redirect_pc);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 1'b1, 12'h340, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{2'b10, 1'b1, 12'h340, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 12'h340, 32'hDEAD_0000, 32'hDEAD_BEFF, 1'b0};
        vecs[3]  = '{2'b10, 1'b0, 12'h340, 32'h0000_0000, 32'h0000_BEFF, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 12'hF14, 32'h0000_0055, 32'h0000_0003, 1'b1};
        vecs[5]  = '{2'b10, 1'b0, 12'hF14, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[6]  = '{2'b10, 1'b0, 12'h7FF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{2'b10, 1'b0, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0};
        vecs[8]  = '{2'b01, 1'b1, 12'h344, 32'h0000_FFFF, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 12'h344, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{2'b01, 1'b1, 12'h341, 32'h0000_0123, 32'h0000_0000, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 12'h341, 32'h0000_0000, 32'h0000_0120, 1'b0};
        vecs[12] = '{2'b01, 1'b1, 12'h305, 32'h0000_0103, 32'h0000_0080, 1'b0};
        vecs[13] = '{2'b10, 1'b0, 12'h305, 32'h0000_0000, 32'h0000_0101, 1'b0};
        vecs[14] = '{2'b10, 1'b0, 12'hF11, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{2'b00, 1'b0, 12'h340, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[16] = '{2'b01, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[17] = '{2'b10, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_0088, 1'b0};
        vecs[18] = '{2'b01, 1'b1, 12'h300, 32'h0000_0000, 32'h0000_0088, 1'b0};
        vecs[19] = '{2'b01, 1'b1, 12'hF11, 32'h0000_0001, 32'h0000_0000, 1'b1};

        rst         = 1'b1;
        idle();
        trap_valid  = 1'b0;
        trap_cause  = '0;
        trap_pc     = '0;
        trap_tval   = '0;
        mret_valid  = 1'b0;
        instret_inc = 1'b0;
        irq_ext     = 1'b0;
        irq_timer   = 1'b0;
        irq_sw      = 1'b0;
        #22;
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_irq_req", {31'b0, irq_req}, 32'd0);
        check("rst_mstatus", mstatus_o, 32'h0);
        chk_rd("rst_mtvec", 12'h305, MTVEC_RST);

        // Table-driven CSR accesses
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].op, vecs[i].we, vecs[i].addr, vecs[i].wsrc);
            sb_push($sformatf("vec%0d_rdata", i), vecs[i].exp_rd);
            sb_push($sformatf("vec%0d_illegal", i), {31'b0, vecs[i].exp_ill});
            #1;
            sb_pop_check(csr_rdata);
            sb_pop_check({31'b0, csr_illegal});
            tick();
        end
        idle();
        chk_rd("ro_write_no_effect", 12'hF11, 32'h0);

        // Trap and MRET (mtvec = 0x101, synchronous cause -> base)
        csr_write(2'b01, 12'h300, 32'h0000_0008);
        event_redirect(1'b1, 1'b0, 32'd2, 32'h102, 32'h13, "trap_redirect", 32'h100);
        check("trap_mstatus", mstatus_o, 32'h0000_1880);
        chk_rd("trap_mepc", 12'h341, 32'h100);
        chk_rd("trap_mcause", 12'h342, 32'd2);
        chk_rd("trap_mtval", 12'h343, 32'h13);
        tick();
        check("redirect_pulse_end", {31'b0, redirect_valid}, 32'd0);
        event_redirect(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, "mret_redirect", 32'h100);
        check("mret_mstatus", mstatus_o, 32'h0000_1888);

        // Vectored interrupt
        csr_write(2'b01, 12'h305, 32'h0000_0201);
        csr_write(2'b01, 12'h304, 32'h0000_0080);
        csr_write(2'b10, 12'h300, 32'h0000_0008);
        irq_timer = 1'b1;
        #1;
        check("irq_req_delay", {31'b0, irq_req}, 32'd0);
        tick();
        check("irq_req_timer", {31'b0, irq_req}, 32'd1);
        check("irq_cause_timer", irq_cause, 32'h8000_0007);
        irq_sw = 1'b1;
        csr_write(2'b10, 12'h304, 32'h0000_0008);
        check("irq_cause_msi", irq_cause, 32'h8000_0003);
        irq_ext = 1'b1;
        csr_write(2'b10, 12'h304, 32'h0000_0800);
        check("irq_cause_mei", irq_cause, 32'h8000_000B);
        chk_rd("mip_read", 12'h344, 32'h0000_0888);
        csr_write(2'b11, 12'h304, 32'h0000_0808);
        check("irq_cause_back_timer", irq_cause, 32'h8000_0007);
        event_redirect(1'b1, 1'b0, 32'h8000_0007, 32'h400, 32'h0, "vec_redirect", 32'h21C);
        check("irq_req_after_trap", {31'b0, irq_req}, 32'd0);
        irq_timer = 1'b0;
        irq_sw    = 1'b0;
        irq_ext   = 1'b0;

        // Counter wrap and override
        csr_write(2'b01, 12'hB80, 32'hFFFF_FFFF);
        csr_write(2'b01, 12'hB00, 32'hFFFF_FFFE);
        chk_rd("mcycle_written", 12'hB00, 32'hFFFF_FFFE);
        chk_rd("mcycleh_written", 12'hB80, 32'hFFFF_FFFF);
        tick();
        chk_rd("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        tick();
        chk_rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        chk_rd("mcycle_wrap_hi", 12'hB80, 32'h0);
        drive(2'b01, 1'b1, 12'hB02, 32'h50);
        instret_inc = 1'b1;
        tick();
        idle();
        instret_inc = 1'b0;
        chk_rd("minstret_write_wins", 12'hB02, 32'h50);
        instret_inc = 1'b1;
        tick();
        instret_inc = 1'b0;
        chk_rd("minstret_inc", 12'hB02, 32'h51);
        chk_rd("minstreth", 12'hB82, 32'h0);

        // Trap + MRET + CSR write together: only trap effects
        csr_write(2'b01, 12'h340, 32'h11);
        csr_write(2'b01, 12'h300, 32'h0000_0008);
        drive(2'b01, 1'b1, 12'h340, 32'h22);
        event_redirect(1'b1, 1'b1, 32'd5, 32'h301, 32'h0, "prio_redirect", 32'h200);
        idle();
        chk_rd("prio_mscratch", 12'h340, 32'h11);
        chk_rd("prio_mepc", 12'h341, 32'h300);
        chk_rd("prio_mcause", 12'h342, 32'd5);
        check("prio_mstatus", mstatus_o, 32'h0000_1880);

        // Reset during a redirect pulse
        event_redirect(1'b1, 1'b0, 32'd1, 32'h500, 32'h0, "pre_rst_redirect", 32'h200);
        rst = 1'b1;
        #1;
        check("rst_mid_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk_rd("rst_mid_mtvec", 12'h305, MTVEC_RST);
        chk_rd("rst_mid_mscratch", 12'h340, 32'h0);
        chk_rd("rst_mid_mcycle", 12'hB00, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
